// File: rtl/vga_pattern_gen.sv
// VGA timing generator with four selectable test patterns (grid, colour bars, gradient, scrolling checker).
// Pixel/line counters advance one step per clock. Every output is registered exactly one cycle behind them.
module vga_pattern_gen #(
  parameter int H_DISPLAY  = 640,
  parameter int H_FRONT    = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BACK     = 48,
  parameter int V_DISPLAY  = 480,
  parameter int V_FRONT    = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BACK     = 33,
  parameter bit SYNC_POL   = 1'b0,
  parameter int COLOR_BITS = 1,
  localparam int H_TOTAL   = H_DISPLAY + H_FRONT + H_SYNC + H_BACK,
  localparam int V_TOTAL   = V_DISPLAY + V_FRONT + V_SYNC + V_BACK,
  localparam int HW        = $clog2(H_TOTAL),
  localparam int VW        = $clog2(V_TOTAL)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [1:0]              mode,
  output logic                    hsync,
  output logic                    vsync,
  output logic                    display_on,
  output logic [HW-1:0]           hpos,
  output logic [VW-1:0]           vpos,
  output logic                    frame_start,
  output logic [3*COLOR_BITS-1:0] rgb
);

  localparam int H_SYNC_START = H_DISPLAY + H_FRONT;
  localparam int H_SYNC_END   = H_SYNC_START + H_SYNC - 1;
  localparam int V_SYNC_START = V_DISPLAY + V_FRONT;
  localparam int V_SYNC_END   = V_SYNC_START + V_SYNC - 1;
  localparam int SEG_W        = H_DISPLAY / 8;
  localparam int SW           = (SEG_W > 1) ? $clog2(SEG_W) : 1;
  localparam logic [COLOR_BITS-1:0] FULL = '1;

  logic            started;
  logic [HW-1:0]   hcnt;
  logic [VW-1:0]   vcnt;
  logic [7:0]      fcnt;
  logic [1:0]      mode_q;
  logic [SW-1:0]   seg_cnt;
  logic [2:0]      bar_idx;
  logic            h_last;
  logic            v_last;

  assign h_last = (hcnt == HW'(H_TOTAL - 1));
  assign v_last = (vcnt == VW'(V_TOTAL - 1));

  // started holds the counters at (0,0) for the first edge after reset,
  // so the first visible pixel (and frame_start) lands on the second edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      started <= 1'b0;
      hcnt    <= '0;
      vcnt    <= '0;
      fcnt    <= '0;
      mode_q  <= '0;
      seg_cnt <= '0;
      bar_idx <= '0;
    end else begin
      started <= 1'b1;
      if (started) begin
        if (h_last) begin
          hcnt    <= '0;
          seg_cnt <= '0;
          bar_idx <= '0;
          if (v_last) begin
            vcnt   <= '0;
            fcnt   <= fcnt + 8'd1;
            mode_q <= mode;
          end else begin
            vcnt <= vcnt + VW'(1);
          end
        end else begin
          hcnt <= hcnt + HW'(1);
          // bar index tracks floor(hcnt*8/H_DISPLAY) without a divider
          if (seg_cnt == SW'(SEG_W - 1)) begin
            seg_cnt <= '0;
            bar_idx <= bar_idx + 3'd1;
          end else begin
            seg_cnt <= seg_cnt + SW'(1);
          end
        end
      end
    end
  end

  logic                  act_area;
  logic                  hs_act;
  logic                  vs_act;
  logic                  chk_bit;
  logic [COLOR_BITS-1:0] r;
  logic [COLOR_BITS-1:0] g;
  logic [COLOR_BITS-1:0] b;

  always_comb begin
    act_area = (hcnt < HW'(H_DISPLAY)) && (vcnt < VW'(V_DISPLAY));
    hs_act   = (hcnt >= HW'(H_SYNC_START)) && (hcnt <= HW'(H_SYNC_END));
    vs_act   = (vcnt >= VW'(V_SYNC_START)) && (vcnt <= VW'(V_SYNC_END));
    chk_bit  = 1'((hcnt + HW'(fcnt)) >> 4) ^ vcnt[4];
    r = '0;
    g = '0;
    b = '0;
    case (mode_q)
      2'd0: begin
        r = (hcnt[2:0] == 3'd0 || vcnt[2:0] == 3'd0) ? FULL : '0;
        g = vcnt[4] ? FULL : '0;
        b = hcnt[4] ? FULL : '0;
      end
      2'd1: begin
        r = bar_idx[1] ? '0 : FULL;
        g = bar_idx[2] ? '0 : FULL;
        b = bar_idx[0] ? '0 : FULL;
      end
      2'd2: begin
        r = COLOR_BITS'(hcnt >> 2);
        g = COLOR_BITS'(hcnt >> 2);
        b = COLOR_BITS'(hcnt >> 2);
      end
      default: begin
        r = chk_bit ? FULL : '0;
        g = chk_bit ? FULL : '0;
        b = chk_bit ? FULL : '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset || !started) begin
      hsync       <= ~SYNC_POL;
      vsync       <= ~SYNC_POL;
      display_on  <= 1'b0;
      frame_start <= 1'b0;
      rgb         <= '0;
      hpos        <= '0;
      vpos        <= '0;
    end else begin
      hsync       <= hs_act ? SYNC_POL : ~SYNC_POL;
      vsync       <= vs_act ? SYNC_POL : ~SYNC_POL;
      display_on  <= act_area;
      frame_start <= (hcnt == '0) && (vcnt == '0);
      rgb         <= act_area ? {b, g, r} : '0;
      hpos        <= hcnt;
      vpos        <= vcnt;
    end
  end

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Bench for vga_pattern_gen: small raster, randomized mode changes, pixel-position reference model.
// Directed checks cover bar colours, gradient value, sync widths, checker scrolling and mid-line reset.
module tb_vga_pattern_gen;

  localparam int HD = 64, HF = 4, HS = 8, HB = 4;
  localparam int VD = 40, VF = 2, VS = 2, VB = 4;
  localparam int HT = HD + HF + HS + HB;
  localparam int VT = VD + VF + VS + VB;
  localparam int HW = $clog2(HT);
  localparam int VW = $clog2(VT);
  localparam bit POL = 1'b1;
  localparam int CB = 4;
  localparam int CW = 3 * CB;
  localparam int FRAME = HT * VT;

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [1:0]    mode = 2'd1;
  logic          hsync, vsync, display_on, frame_start;
  logic [HW-1:0] hpos;
  logic [VW-1:0] vpos;
  logic [CW-1:0] rgb;

  always #5 clk = ~clk;

  vga_pattern_gen #(
    .H_DISPLAY(HD), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_DISPLAY(VD), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .SYNC_POL(POL), .COLOR_BITS(CB)
  ) dut (
    .clk(clk), .reset(reset), .mode(mode),
    .hsync(hsync), .vsync(vsync), .display_on(display_on),
    .hpos(hpos), .vpos(vpos), .frame_start(frame_start), .rgb(rgb)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      if (failures <= 25)
        $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Tracks which raster position the DUT should be showing; patterns come from the rules directly.
  bit m_started = 1'b0;
  int m_h = 0, m_v = 0, m_f = 0, m_mode = 0;
  bit e_known = 1'b0, e_show = 1'b0;
  int e_h = 0, e_v = 0, e_f = 0, e_m = 0;
  int bar_tab[8] = '{7, 6, 3, 2, 5, 4, 1, 0};

  function automatic logic [CW-1:0] ref_rgb(input int h, input int v, input int f, input int m);
    logic [CB-1:0] r, g, b;
    int k, on;
    r = '0; g = '0; b = '0;
    if (!(h < HD && v < VD)) return '0;
    case (m)
      0: begin
        r = (h % 8 == 0 || v % 8 == 0) ? 4'hF : 4'h0;
        g = ((v / 16) % 2 == 1) ? 4'hF : 4'h0;
        b = ((h / 16) % 2 == 1) ? 4'hF : 4'h0;
      end
      1: begin
        k = (h * 8) / HD;
        r = ((bar_tab[k] / 4) % 2 == 1) ? 4'hF : 4'h0;
        g = ((bar_tab[k] / 2) % 2 == 1) ? 4'hF : 4'h0;
        b = (bar_tab[k] % 2 == 1) ? 4'hF : 4'h0;
      end
      2: begin
        r = 4'((h / 4) % 16);
        g = r;
        b = r;
      end
      default: begin
        on = (((h + f) % (1 << HW)) / 16) % 2;
        on = on ^ ((v / 16) % 2);
        r = (on == 1) ? 4'hF : 4'h0;
        g = r;
        b = r;
      end
    endcase
    return {b, g, r};
  endfunction

  task automatic model_step();
    e_known = 1'b1;
    if (reset) begin
      e_show = 1'b0; m_started = 1'b0;
      m_h = 0; m_v = 0; m_f = 0; m_mode = 0;
    end else if (!m_started) begin
      m_started = 1'b1;
      e_show = 1'b0;
    end else begin
      e_show = 1'b1;
      e_h = m_h; e_v = m_v; e_f = m_f; e_m = m_mode;
      if (m_h == HT - 1 && m_v == VT - 1) begin
        m_mode = int'(mode);
        m_f = (m_f + 1) % 256;
      end
      m_h++;
      if (m_h == HT) begin
        m_h = 0;
        m_v = (m_v + 1) % VT;
      end
    end
  endtask

  // ---------------- monitor state ----------------
  int hs_cnt = 0, vs_cnt = 0, disp_cnt = 0;
  logic prev_hs = 1'b0;
  logic [CW-1:0] prev_rgb = '0;
  int edge_pos = 0, last_edge = 0;
  bit edge_found = 1'b0, edge_valid = 1'b0;

  task automatic compare_outputs();
    logic exp_hs, exp_vs;
    if (!e_known) return;
    if (!e_show) begin
      check("rst_hpos", 32'(hpos), 0);
      check("rst_vpos", 32'(vpos), 0);
      check("rst_hsync", 32'(hsync), 32'(!POL));
      check("rst_vsync", 32'(vsync), 32'(!POL));
      check("rst_disp", 32'(display_on), 0);
      check("rst_fs", 32'(frame_start), 0);
      check("rst_rgb", 32'(rgb), 0);
      hs_cnt = 0; vs_cnt = 0; disp_cnt = 0; edge_valid = 1'b0;
      prev_hs = hsync;
      return;
    end
    exp_hs = (e_h >= HD + HF && e_h < HD + HF + HS) ? POL : !POL;
    exp_vs = (e_v >= VD + VF && e_v < VD + VF + VS) ? POL : !POL;
    check("hpos", 32'(hpos), 32'(e_h));
    check("vpos", 32'(vpos), 32'(e_v));
    check("hsync", 32'(hsync), 32'(exp_hs));
    check("vsync", 32'(vsync), 32'(exp_vs));
    check("display_on", 32'(display_on), 32'(e_h < HD && e_v < VD));
    check("frame_start", 32'(frame_start), 32'(e_h == 0 && e_v == 0));
    check("rgb", 32'(rgb), 32'(ref_rgb(e_h, e_v, e_f, e_m)));

    // colour bar and gradient spot values on line 0
    if (e_m == 1 && e_v == 0) begin
      if (e_h == 0)  check("bar_h0", 32'(rgb), 32'hFFF);
      if (e_h == 8)  check("bar_h8", 32'(rgb), 32'h0FF);
      if (e_h == 16) check("bar_h16", 32'(rgb), 32'hFF0);
      if (e_h == 63) check("bar_h63", 32'(rgb), 32'h000);
      if (e_h == 64) check("bar_h64_blank", 32'(rgb), 32'h000);
    end
    if (e_m == 2 && e_v == 0 && e_h == 8) check("grad_h8", 32'(rgb), 32'h222);

    // sync widths, sync start position and active-pixel count
    if (hsync == POL && prev_hs != POL) check("hsync_start", 32'(hpos), HD + HF);
    prev_hs = hsync;
    if (hsync == POL) hs_cnt++;
    if (vsync == POL) vs_cnt++;
    if (display_on) disp_cnt++;
    if (e_h == HT - 1) begin
      check("hsync_width", hs_cnt, HS);
      hs_cnt = 0;
    end
    if (e_h == HT - 1 && e_v == VT - 1) begin
      check("vsync_cycles", vs_cnt, VS * HT);
      check("disp_count", disp_cnt, HD * VD);
      vs_cnt = 0; disp_cnt = 0;
    end

    // checker edge on line 0 must move one pixel left per frame
    if (e_v == 0) begin
      if (e_h == 0) edge_found = 1'b0;
      else if (e_h < HD && !edge_found && rgb != prev_rgb) begin
        edge_pos = e_h;
        edge_found = 1'b1;
      end
      if (e_h == HD - 1) begin
        if (e_m == 3 && edge_found) begin
          if (edge_valid) check("chk_shift", edge_pos, (last_edge == 1) ? 16 : last_edge - 1);
          last_edge = edge_pos;
          edge_valid = 1'b1;
        end else begin
          edge_valid = 1'b0;
        end
      end
      prev_rgb = rgb;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick(input logic r, input logic [1:0] md);
    @(negedge clk);
    compare_outputs();
    reset = r;
    mode = md;
    model_step();
  endtask

  task automatic run_to(input int h, input int v, input logic [1:0] md);
    for (int i = 0; i < 3 * FRAME; i++) begin
      if (m_h == h && m_v == v) return;
      tick(1'b0, md);
    end
    check("run_to_timeout", 1, 0);
  endtask

  task automatic run_frames(input int n, input logic [1:0] md);
    for (int i = 0; i < n; i++) begin
      tick(1'b0, md);
      run_to(0, 0, md);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    tick(1'b1, 2'd1);
    tick(1'b1, 2'd1);
    check("rst_hsync_low", 32'(hsync), 0);
    check("rst_vsync_low", 32'(vsync), 0);
    tick(1'b1, 2'd1);
    tick(1'b0, 2'd1);

    run_frames(1, 2'd1);     // frame 0: grid from reset, loads bars
    run_to(0, 10, 2'd1);     // frame 1: bars
    run_frames(1, 2'd0);     // request grid for frame 2
    run_to(30, 30, 2'd0);    // frame 2: grid, switch request mid-frame
    run_frames(1, 2'd2);     // grid persists, gradient loaded
    run_frames(1, 2'd3);     // frame 3: gradient, loads checker
    run_frames(3, 2'd3);     // frames 4..6: scrolling checker
    run_to(70, 5, 2'd3);     // frame 7: DUT now shows hpos 69, inside hsync

    tick(1'b1, 2'd3);
    tick(1'b0, 2'd3);
    check("hsync_after_rst", 32'(hsync), 32'(!POL));
    tick(1'b0, 2'd3);
    check("fs_edge1", 32'(frame_start), 0);
    tick(1'b0, 2'd3);
    check("fs_edge2", 32'(frame_start), 1);

    // randomized mode churn across several frames
    for (int i = 0; i < 4 * FRAME; i++) begin
      logic [1:0] md;
      md = mode;
      if ($urandom_range(0, 399) == 0) md = 2'($urandom_range(0, 3));
      tick(1'b0, md);
    end
    tick(1'b0, mode);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
